// File: rtl/lcd_if_ctrl_if.sv
// Bundle of the sequencer handshake, output-buffer read port and 8080 LCD bus for lcd_if_ctrl.
// LCD_IF_BYTE_MODE_EN narrows oLcdData to 8 bits.
interface lcd_if_ctrl_if #(
    parameter int unsigned P_ADDR_W = 10,
    parameter int unsigned P_DATA_W = 16
);
`ifdef LCD_IF_BYTE_MODE_EN
    localparam int unsigned LcdW = 8;
`else
    localparam int unsigned LcdW = P_DATA_W;
`endif

    logic                wStLcdIf;
    logic                wLcdIfDone;
    logic                oBusy;
    logic                oOBufRdEn;
    logic [P_ADDR_W-1:0] oOBufRdAddr;
    logic [P_DATA_W-1:0] wOBufRdData;
    logic                oLcdCsn;
    logic                oLcdRs;
    logic                oLcdWrn;
    logic [LcdW-1:0]     oLcdData;

    modport master (
        input  wStLcdIf, wOBufRdData,
        output wLcdIfDone, oBusy, oOBufRdEn, oOBufRdAddr, oLcdCsn, oLcdRs, oLcdWrn, oLcdData
    );

    modport slave (
        output wStLcdIf, wOBufRdData,
        input  wLcdIfDone, oBusy, oOBufRdEn, oOBufRdAddr, oLcdCsn, oLcdRs, oLcdWrn, oLcdData
    );
endinterface

// File: rtl/lcd_if_ctrl.sv
// LCD interface engine: sends the memory-write command, then streams one frame of pixels from the
// output buffer onto an 8080 bus. Define LCD_IF_BYTE_MODE_EN for an 8-bit bus, two writes per pixel.
module lcd_if_ctrl #(
    parameter int unsigned P_NUM_PIX   = 784,
    parameter int unsigned P_ADDR_W    = 10,
    parameter int unsigned P_DATA_W    = 16,
    parameter int unsigned P_WR_LO     = 2,
    parameter int unsigned P_WR_HI     = 2,
    parameter logic [15:0] P_CMD_MEMWR = 16'h002C
) (
    input logic           iClk,
    input logic           wRst,
    input logic           wEnClk,
    lcd_if_ctrl_if.master bus
);
    localparam int unsigned W   = P_WR_LO + P_WR_HI;
    localparam int unsigned PhW = $clog2(W);
    localparam logic [PhW-1:0]      LoLast  = PhW'(P_WR_LO - 1);
    localparam logic [PhW-1:0]      WrLast  = PhW'(W - 1);
    localparam logic [P_ADDR_W-1:0] LastPix = P_ADDR_W'(P_NUM_PIX - 1);
`ifdef LCD_IF_BYTE_MODE_EN
    localparam int unsigned LcdW = 8;
`else
    localparam int unsigned LcdW = P_DATA_W;
`endif
    localparam logic [LcdW-1:0] CmdWord = LcdW'(P_CMD_MEMWR);

    typedef enum logic [2:0] {StIdle, StCmdWr, StRdReq, StRdWait, StPixWr, StDone} stateT;

    stateT               stateQ;
    logic [PhW-1:0]      phaseQ;
    logic [P_ADDR_W-1:0] pixQ;
    logic                csnQ, rsQ, wrnQ, rdEnQ, busyQ, doneQ;
    logic [LcdW-1:0]     dataQ;
`ifdef LCD_IF_BYTE_MODE_EN
    logic                byteSelQ;
    logic [7:0]          pixLoQ;
`endif

    always_ff @(posedge iClk) begin
        if (wRst) begin
            stateQ   <= StIdle;
            phaseQ   <= '0;
            pixQ     <= '0;
            csnQ     <= 1'b1;
            rsQ      <= 1'b0;
            wrnQ     <= 1'b1;
            dataQ    <= '0;
            rdEnQ    <= 1'b0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
`ifdef LCD_IF_BYTE_MODE_EN
            byteSelQ <= 1'b0;
            pixLoQ   <= '0;
`endif
        end else if (wEnClk) begin
            unique case (stateQ)
                StIdle: begin
                    if (bus.wStLcdIf) begin
                        stateQ <= StCmdWr;
                        csnQ   <= 1'b0;
                        rsQ    <= 1'b0;
                        dataQ  <= CmdWord;
                        wrnQ   <= 1'b0;
                        phaseQ <= '0;
                        busyQ  <= 1'b1;
                    end
                end
                StCmdWr, StPixWr: begin
                    if (phaseQ == LoLast) wrnQ <= 1'b1;
                    if (phaseQ == WrLast) begin
                        phaseQ <= '0;
                        if (stateQ == StCmdWr) begin
                            rsQ    <= 1'b1;
                            pixQ   <= '0;
                            rdEnQ  <= 1'b1;
                            stateQ <= StRdReq;
                        end
`ifdef LCD_IF_BYTE_MODE_EN
                        // Low byte follows immediately without another buffer read.
                        else if (!byteSelQ) begin
                            byteSelQ <= 1'b1;
                            dataQ    <= pixLoQ;
                            wrnQ     <= 1'b0;
                        end
`endif
                        else if (pixQ == LastPix) begin
                            stateQ <= StDone;
                            doneQ  <= 1'b1;
                            csnQ   <= 1'b1;
                            rsQ    <= 1'b0;
                        end else begin
                            pixQ   <= pixQ + 1'b1;
                            rdEnQ  <= 1'b1;
                            stateQ <= StRdReq;
                        end
                    end else begin
                        phaseQ <= phaseQ + 1'b1;
                    end
                end
                StRdReq: begin
                    rdEnQ  <= 1'b0;
                    stateQ <= StRdWait;
                end
                StRdWait: begin
`ifdef LCD_IF_BYTE_MODE_EN
                    dataQ    <= bus.wOBufRdData[15:8];
                    pixLoQ   <= bus.wOBufRdData[7:0];
                    byteSelQ <= 1'b0;
`else
                    dataQ    <= bus.wOBufRdData;
`endif
                    wrnQ   <= 1'b0;
                    phaseQ <= '0;
                    stateQ <= StPixWr;
                end
                StDone: begin
                    doneQ  <= 1'b0;
                    busyQ  <= 1'b0;
                    stateQ <= StIdle;
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

    assign bus.oLcdCsn     = csnQ;
    assign bus.oLcdRs      = rsQ;
    assign bus.oLcdWrn     = wrnQ;
    assign bus.oLcdData    = dataQ;
    assign bus.oOBufRdEn   = rdEnQ;
    assign bus.oOBufRdAddr = pixQ;
    assign bus.oBusy       = busyQ;
    assign bus.wLcdIfDone  = doneQ;
endmodule

// File: tb/tb_lcd_if_ctrl.sv
// Directed bench for lcd_if_ctrl: reset, basic frame, clock-enable stall, start while busy and
// reset mid-frame; expectations adapt to LCD_IF_BYTE_MODE_EN.
module tb_lcd_if_ctrl;
    localparam int N      = 4;
    localparam int WR_LO  = 2;
    localparam int WR_HI  = 2;
    localparam int W      = WR_LO + WR_HI;
`ifdef LCD_IF_BYTE_MODE_EN
    localparam int LW     = 8;
    localparam int PIX    = 2 + 2 * W;
    localparam int NW     = 1 + 2 * N;
`else
    localparam int LW     = 16;
    localparam int PIX    = 2 + W;
    localparam int NW     = 1 + N;
`endif
    localparam int DONE_AT = W + N * PIX;

    logic iClk = 1'b0;
    logic wRst;
    logic wEnClk;

    lcd_if_ctrl_if #(.P_ADDR_W(10), .P_DATA_W(16)) bus ();

    lcd_if_ctrl #(
        .P_NUM_PIX  (N),
        .P_ADDR_W   (10),
        .P_DATA_W   (16),
        .P_WR_LO    (WR_LO),
        .P_WR_HI    (WR_HI),
        .P_CMD_MEMWR(16'h002C)
    ) dut (
        .iClk  (iClk),
        .wRst  (wRst),
        .wEnClk(wEnClk),
        .bus   (bus)
    );

    always #5 iClk = ~iClk;

    logic [15:0]   mem  [4];
    logic [LW-1:0] expD [NW];
    bit            expR [NW];

    always @(posedge iClk) if (bus.oOBufRdEn) bus.wOBufRdData <= mem[bus.oOBufRdAddr[1:0]];

    int nChecks = 0;
    int nPass   = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Bus monitor: one entry per completed write (rising oLcdWrn).
    logic [LW-1:0] wrDataQ [$];
    bit            wrRsQ   [$];
    int            wrLoQ   [$];
    bit            wrStabQ [$];
    logic [9:0]    rdAddrQ [$];
    int            doneCnt = 0;

    initial begin
        logic [LW-1:0] curData;
        bit curRs, curStab, prevWrn, prevRdEn, prevDone;
        int curLo;
        curData = '0; curRs = 0; curStab = 1; curLo = 0;
        prevWrn = 1; prevRdEn = 0; prevDone = 0;
        forever begin
            @(negedge iClk);
            if (!bus.oLcdWrn) begin
                if (prevWrn) begin
                    curData = bus.oLcdData; curRs = bus.oLcdRs; curLo = 0; curStab = 1;
                end else if (bus.oLcdData !== curData || bus.oLcdRs !== curRs) begin
                    curStab = 0;
                end
                if (wEnClk) curLo++;
            end else if (!prevWrn) begin
                if (bus.oLcdData !== curData || bus.oLcdRs !== curRs) curStab = 0;
                wrDataQ.push_back(curData);
                wrRsQ.push_back(curRs);
                wrLoQ.push_back(curLo);
                wrStabQ.push_back(curStab);
            end
            prevWrn = bus.oLcdWrn;
            if (bus.oOBufRdEn && !prevRdEn) rdAddrQ.push_back(bus.oOBufRdAddr);
            prevRdEn = bus.oOBufRdEn;
            if (bus.wLcdIfDone && !prevDone) doneCnt++;
            prevDone = bus.wLcdIfDone;
        end
    end

    task automatic clearMon();
        wrDataQ.delete(); wrRsQ.delete(); wrLoQ.delete(); wrStabQ.delete(); rdAddrQ.delete();
        doneCnt = 0;
    endtask

    task automatic startFrame();
        @(posedge iClk); #1;
        bus.wStLcdIf = 1'b1;
        wEnClk = 1'b1;
        @(posedge iClk); #1;
        bus.wStLcdIf = 1'b0;
    endtask

    // Counts enabled edges after the accept edge until done, an abort point, or the budget.
    task automatic waitDone(input bit stall, input int restartAt, input int abortAt,
                            output int enCyc, output bit seen);
        bit enNow;
        enCyc = 0;
        seen = 0;
        wEnClk = stall ? 1'b0 : 1'b1;
        for (int i = 0; i < 2000; i++) begin
            enNow = wEnClk;
            @(posedge iClk);
            if (enNow) enCyc++;
            #1;
            bus.wStLcdIf = enNow && (enCyc == restartAt);
            if (bus.wLcdIfDone) begin
                seen = 1;
                break;
            end
            if (enCyc == abortAt) break;
            if (stall) wEnClk = ~wEnClk;
        end
        bus.wStLcdIf = 1'b0;
        wEnClk = 1'b1;
    endtask

    task automatic checkFrame(input string tag);
        checkEq({tag, "_nwr"}, 32'(wrDataQ.size()), 32'(NW));
        for (int i = 0; i < NW && i < wrDataQ.size(); i++) begin
            checkEq($sformatf("%s_data%0d", tag, i), 32'(wrDataQ[i]), 32'(expD[i]));
            checkEq($sformatf("%s_rs%0d", tag, i), 32'(wrRsQ[i]), 32'(expR[i]));
            checkEq($sformatf("%s_wrlo%0d", tag, i), 32'(wrLoQ[i]), 32'(WR_LO));
            checkEq($sformatf("%s_stable%0d", tag, i), 32'(wrStabQ[i]), 32'd1);
        end
        checkEq({tag, "_nrd"}, 32'(rdAddrQ.size()), 32'(N));
        for (int i = 0; i < N && i < rdAddrQ.size(); i++)
            checkEq($sformatf("%s_addr%0d", tag, i), 32'(rdAddrQ[i]), 32'(i));
    endtask

    task automatic settleDone(input string tag);
        @(posedge iClk); #1;
        checkEq({tag, "_done_once"}, 32'(bus.wLcdIfDone), 32'd0);
        checkEq({tag, "_idle_busy"}, 32'(bus.oBusy), 32'd0);
        repeat (3) @(posedge iClk);
        #1;
        checkEq({tag, "_ndone"}, 32'(doneCnt), 32'd1);
    endtask

    initial begin
        int  enCyc;
        bit  seen;
        int  idleBad;
`ifdef LCD_IF_BYTE_MODE_EN
        mem = '{16'hABCD, 16'h1234, 16'h5A6B, 16'hC7D8};
        expD[0] = 8'h2C;
        expR[0] = 0;
        for (int i = 0; i < N; i++) begin
            expD[1 + 2 * i] = mem[i][15:8];
            expD[2 + 2 * i] = mem[i][7:0];
            expR[1 + 2 * i] = 1;
            expR[2 + 2 * i] = 1;
        end
`else
        mem = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        expD[0] = 16'h002C;
        expR[0] = 0;
        for (int i = 0; i < N; i++) begin
            expD[1 + i] = mem[i];
            expR[1 + i] = 1;
        end
`endif
        wRst = 1'b1;
        wEnClk = 1'b1;
        bus.wStLcdIf = 1'b0;
        bus.wOBufRdData = '0;
        repeat (2) @(posedge iClk);
        #1;
        checkEq("rst_csn", 32'(bus.oLcdCsn), 32'd1);
        checkEq("rst_wrn", 32'(bus.oLcdWrn), 32'd1);
        checkEq("rst_rs", 32'(bus.oLcdRs), 32'd0);
        checkEq("rst_data", 32'(bus.oLcdData), 32'd0);
        checkEq("rst_rden", 32'(bus.oOBufRdEn), 32'd0);
        checkEq("rst_addr", 32'(bus.oOBufRdAddr), 32'd0);
        checkEq("rst_busy", 32'(bus.oBusy), 32'd0);
        checkEq("rst_done", 32'(bus.wLcdIfDone), 32'd0);
        wRst = 1'b0;
        idleBad = 0;
        repeat (20) begin
            @(posedge iClk); #1;
            if (bus.oLcdCsn !== 1'b1 || bus.oLcdWrn !== 1'b1 || bus.oBusy !== 1'b0 ||
                bus.wLcdIfDone !== 1'b0) idleBad++;
        end
        checkEq("idle_quiet", 32'(idleBad), 32'd0);

        // Basic frame.
        clearMon();
        startFrame();
        checkEq("acc_busy", 32'(bus.oBusy), 32'd1);
        checkEq("acc_csn", 32'(bus.oLcdCsn), 32'd0);
        checkEq("acc_rs", 32'(bus.oLcdRs), 32'd0);
        waitDone(1'b0, -1, -1, enCyc, seen);
        checkEq("basic_seen", 32'(seen), 32'd1);
        checkEq("basic_latency", 32'(enCyc), 32'(DONE_AT));
        checkEq("basic_done_csn", 32'(bus.oLcdCsn), 32'd1);
        checkEq("basic_done_rs", 32'(bus.oLcdRs), 32'd0);
        settleDone("basic");
        checkEq("basic_addr_hold", 32'(bus.oOBufRdAddr), 32'(N - 1));
        checkFrame("basic");

        // Clock enable toggling every cycle.
        clearMon();
        startFrame();
        waitDone(1'b1, -1, -1, enCyc, seen);
        checkEq("stall_seen", 32'(seen), 32'd1);
        checkEq("stall_latency", 32'(enCyc), 32'(DONE_AT));
        settleDone("stall");
        checkFrame("stall");

        // Second start during the second pixel's write.
        clearMon();
        startFrame();
        waitDone(1'b0, W + PIX + 3, -1, enCyc, seen);
        checkEq("restart_seen", 32'(seen), 32'd1);
        checkEq("restart_latency", 32'(enCyc), 32'(DONE_AT));
        settleDone("restart");
        checkFrame("restart");

        // Reset mid-frame, then a fresh frame.
        clearMon();
        startFrame();
        waitDone(1'b0, -1, W + 2 * PIX + 3, enCyc, seen);
        checkEq("abort_early", 32'(seen), 32'd0);
        wRst = 1'b1;
        @(posedge iClk); #1;
        wRst = 1'b0;
        checkEq("abort_csn", 32'(bus.oLcdCsn), 32'd1);
        checkEq("abort_wrn", 32'(bus.oLcdWrn), 32'd1);
        checkEq("abort_busy", 32'(bus.oBusy), 32'd0);
        checkEq("abort_addr", 32'(bus.oOBufRdAddr), 32'd0);
        repeat (60) @(posedge iClk);
        #1;
        checkEq("abort_nodone", 32'(doneCnt), 32'd0);
        clearMon();
        startFrame();
        waitDone(1'b0, -1, -1, enCyc, seen);
        checkEq("replay_seen", 32'(seen), 32'd1);
        checkEq("replay_latency", 32'(enCyc), 32'(DONE_AT));
        settleDone("replay");
        checkFrame("replay");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
